data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, data/address width.
REQ-002 Parameter: DEPTH, default 512, number of data-memory words; valid addresses are 0..DEPTH-1.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mN_req  in  1  request from requester N (N=0 core load/store, N=1 DMA/debug).
REQ-006 mN_we  in  1  1 = write, 0 = read.
REQ-007 mN_addr  in  WIDTH  word address.
REQ-008 mN_wdata  in  WIDTH  write data.
REQ-009 mN_gnt  out  1  request accepted this cycle.
REQ-010 mN_rvalid  out  1  one-cycle completion pulse for reads and writes.
REQ-011 mN_rdata  out  WIDTH  read data, valid while mN_rvalid.
REQ-012 mN_err  out  1  address out of range, valid while mN_rvalid.
REQ-013 mem_trig, mem_read, mem_write  out  1 each  data-memory strobes.
REQ-014 mem_addr, mem_wdata  out  WIDTH  data-memory address and write data.
REQ-015 mem_rdata  in  WIDTH  data-memory registered read data, valid the cycle after a read strobe.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; IDLE->ISSUE on any mN_req, ISSUE->RESP always, RESP->IDLE always.
REQ-017 In IDLE, mN_gnt is combinational: asserted for exactly one requester when its mN_req=1; no grant outside IDLE.
REQ-018 Requesters hold mN_req/we/addr/wdata stable until mN_gnt; arbiter captures them on the grant edge.
REQ-019 Arbitration round-robin: with both requesting, grant the requester not granted last; single requester is always granted.
REQ-020 ISSUE (cycle T+1 after grant at T): mem_trig=1, mem_read=~we, mem_write=we, mem_addr/mem_wdata = captured values, if address < DEPTH.
REQ-021 RESP (T+2): granted port mN_rvalid=1; reads drive mN_rdata=mem_rdata; writes drive mN_rdata=0.
REQ-022 Address >= DEPTH: grant normally, no mem strobe in ISSUE, RESP with mN_err=1, mN_rdata=0.
REQ-023 Non-granted port outputs gnt/rvalid/err=0 and rdata=0 in every cycle.
REQ-024 Throughput: one transaction per 3 cycles; mN_req held through RESP is re-arbitrated in the following IDLE.
REQ-025 mem_trig, mem_read, mem_write are never 1 outside ISSUE; mem_read and mem_write never 1 together.

Reset
REQ-026 rst_n low: state=IDLE, last-grant pointer = port 1 (port 0 wins first contention), captured regs = 0.
REQ-027 During reset all outputs = 0.
REQ-028 Reset in ISSUE or RESP aborts the transaction: no further mem strobe, no mN_rvalid for it.

Structure
REQ-029 Shared package dmem_arb_pkg holds the state type (IDLE/ISSUE/RESP), port count (2) and DEPTH default.
REQ-030 One sub-module, rr_arbiter2: 2-way round-robin grant with last-grant pointer; FSM and capture regs stay in data_mem_arbiter.

Verification
REQ-031 m0 read addr 5, m1 idle, memory word 5 = 0x00000005 -> m0_gnt at T, mem_trig+mem_read at T+1 with mem_addr 5, m0_rvalid at T+2 with m0_rdata=0x00000005.
REQ-032 m1 write addr 3 data 0xDEADBEEF, then m0 read addr 3 -> mem_write pulse at T+1, m1_rvalid at T+2, m0 read returns 0xDEADBEEF.
REQ-033 m0 and m1 both request continuously after reset -> grants alternate m0, m1, m0, m1, each 3 cycles apart.
REQ-034 m0 read addr 512 -> no mem_trig, m0_rvalid with m0_err=1, m0_rdata=0.
REQ-035 rst_n low during ISSUE of an m1 write -> mem strobes drop immediately, no m1_rvalid; after release, next contention grants m0 first.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// dmem_arb_pkg : shared types and constants for the data-memory arbiter
// Rev 1.0
// ============================================================================
package dmem_arb_pkg;

  localparam int c_num_ports     = 2;
  localparam int c_depth_default = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// rr_arbiter2 : 2-way round-robin grant with a last-grant pointer
// Rev 1.0
// ============================================================================
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_en,
  input  logic [c_num_ports-1:0] i_req,
  output logic [c_num_ports-1:0] o_gnt
);

  // Pointer holds the most recent winner; reset to port 1 so port 0 wins first.
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (o_gnt != 2'b00) begin
      r_last <= o_gnt[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// data_mem_arbiter : two requesters sharing one data memory, 3-cycle transactions
// Rev 1.0
// ============================================================================
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = c_depth_default
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_err,
  output logic             mem_trig,
  output logic             mem_read,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [WIDTH:0] c_depth = (WIDTH+1)'(DEPTH);

  state_t                   r_state, w_next;
  logic [c_num_ports-1:0]   w_req, w_gnt;
  logic                     w_en;
  logic                     w_sel_we, w_sel_oob;
  logic [WIDTH-1:0]         w_sel_addr, w_sel_wdata, w_resp_data;
  logic                     r_port, r_we, r_oob;
  logic [WIDTH-1:0]         r_addr, r_wdata;

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  assign w_req = {m1_req, m0_req};
  assign w_en  = (r_state == IDLE) && rst_n;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_en),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign w_sel_oob   = {1'b0, w_sel_addr} >= c_depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port  <= 1'b0;
      r_we    <= 1'b0;
      r_oob   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_gnt != 2'b00) begin
      r_port  <= w_gnt[1];
      r_we    <= w_sel_we;
      r_oob   <= w_sel_oob;
      r_addr  <= w_sel_addr;
      r_wdata <= w_sel_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt != 2'b00) w_next = ISSUE;
      ISSUE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Writes and out-of-range accesses complete with zero data.
  assign w_resp_data = (r_we || r_oob) ? '0 : mem_rdata;

  always_comb begin
    m0_gnt    = w_gnt[0];
    m1_gnt    = w_gnt[1];
    m0_rvalid = 1'b0;
    m1_rvalid = 1'b0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    mem_trig  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      ISSUE: begin
        if (!r_oob) begin
          mem_trig  = 1'b1;
          mem_read  = ~r_we;
          mem_write = r_we;
          mem_addr  = r_addr;
          mem_wdata = r_wdata;
        end
      end
      RESP: begin
        if (r_port) begin
          m1_rvalid = 1'b1;
          m1_err    = r_oob;
          m1_rdata  = w_resp_data;
        end else begin
          m0_rvalid = 1'b1;
          m0_err    = r_oob;
          m0_rdata  = w_resp_data;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_data_mem_arbiter : directed vector bench for data_mem_arbiter
// Rev 1.0
// ============================================================================
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_clr = 1'b1;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_trig, mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:511];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WIDTH(32), .DEPTH(512)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_trig(mem_trig), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory with registered read; word i initialised to i.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 32'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_trig && mem_read)  mem_rdata <= mem[mem_addr[8:0]];
      if (mem_trig && mem_write) mem[mem_addr[8:0]] <= mem_wdata;
    end
  end

  typedef struct packed {
    logic        req0, we0;
    logic [31:0] addr0, wdata0;
    logic        req1, we1;
    logic [31:0] addr1, wdata1;
  } in_t;

  typedef struct packed {
    logic        g0, g1, v0, v1, e0, e1, t, r, w;
    logic [31:0] rd0, rd1, ma, mw;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vq[$];

  function automatic in_t p0(logic we, logic [31:0] a, logic [31:0] d);
    in_t x = '0;
    x.req0 = 1'b1; x.we0 = we; x.addr0 = a; x.wdata0 = d;
    return x;
  endfunction

  function automatic in_t p1(logic we, logic [31:0] a, logic [31:0] d);
    in_t x = '0;
    x.req1 = 1'b1; x.we1 = we; x.addr1 = a; x.wdata1 = d;
    return x;
  endfunction

  function automatic out_t eg(int port);
    out_t o = '0;
    if (port == 0) o.g0 = 1'b1; else o.g1 = 1'b1;
    return o;
  endfunction

  function automatic out_t eiss(logic we, logic [31:0] a, logic [31:0] d);
    out_t o = '0;
    o.t = 1'b1; o.r = ~we; o.w = we; o.ma = a; o.mw = d;
    return o;
  endfunction

  function automatic out_t ers(int port, logic [31:0] rd, logic err);
    out_t o = '0;
    if (port == 0) begin o.v0 = 1'b1; o.e0 = err; o.rd0 = rd; end
    else           begin o.v1 = 1'b1; o.e1 = err; o.rd1 = rd; end
    return o;
  endfunction

  function automatic out_t cur();
    out_t o;
    o.g0 = m0_gnt; o.g1 = m1_gnt; o.v0 = m0_rvalid; o.v1 = m1_rvalid;
    o.e0 = m0_err; o.e1 = m1_err; o.t = mem_trig; o.r = mem_read; o.w = mem_write;
    o.rd0 = m0_rdata; o.rd1 = m1_rdata; o.ma = mem_addr; o.mw = mem_wdata;
    return o;
  endfunction

  task automatic drive(input in_t x);
    m0_req = x.req0; m0_we = x.we0; m0_addr = x.addr0; m0_wdata = x.wdata0;
    m1_req = x.req1; m1_we = x.we1; m1_addr = x.addr1; m1_wdata = x.wdata1;
  endtask

  task automatic chk(input string nm, input out_t exp);
    out_t act = cur();
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    in_t  both;
    out_t e;
    int   g;

    both = p0(1'b0, 32'd1, 32'd0) | p1(1'b0, 32'd2, 32'd0);

    // Reset: outputs quiet even with both requesters active.
    drive(both);
    #1 chk("reset_out", '0);
    @(negedge clk);
    chk("reset_out_hold", '0);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;

    // Continuous contention: m0 first, then alternate every 3 cycles.
    for (int k = 0; k < 15; k++) begin
      if (k > 0) @(negedge clk);
      drive(both);
      g = (k / 3) % 2;
      case (k % 3)
        0:       e = eg(g);
        1:       e = eiss(1'b0, (g == 0) ? 32'd1 : 32'd2, 32'd0);
        default: e = ers(g, (g == 0) ? 32'd1 : 32'd2, 1'b0);
      endcase
      #1 chk($sformatf("contend_k%0d", k), e);
    end

    // Directed table, one row per cycle starting in IDLE.
    vq.push_back({in_t'('0),                             out_t'('0)});
    vq.push_back({p0(1'b0, 32'd5, 32'd0),                eg(0)});
    vq.push_back({in_t'('0),                             eiss(1'b0, 32'd5, 32'd0)});
    vq.push_back({in_t'('0),                             ers(0, 32'd5, 1'b0)});
    vq.push_back({p1(1'b1, 32'd3, 32'hDEADBEEF),         eg(1)});
    vq.push_back({in_t'('0),                             eiss(1'b1, 32'd3, 32'hDEADBEEF)});
    vq.push_back({in_t'('0),                             ers(1, 32'd0, 1'b0)});
    vq.push_back({p0(1'b0, 32'd3, 32'd0),                eg(0)});
    vq.push_back({in_t'('0),                             eiss(1'b0, 32'd3, 32'd0)});
    vq.push_back({in_t'('0),                             ers(0, 32'hDEADBEEF, 1'b0)});
    vq.push_back({p0(1'b0, 32'd512, 32'd0),              eg(0)});
    vq.push_back({p1(1'b0, 32'd511, 32'd0),              out_t'('0)});
    vq.push_back({p1(1'b0, 32'd511, 32'd0),              ers(0, 32'd0, 1'b1)});
    vq.push_back({p1(1'b0, 32'd511, 32'd0),              eg(1)});
    vq.push_back({in_t'('0),                             eiss(1'b0, 32'd511, 32'd0)});
    vq.push_back({in_t'('0),                             ers(1, 32'h1FF, 1'b0)});
    vq.push_back({p1(1'b1, 32'hFFFFFFFF, 32'h12345678),  eg(1)});
    vq.push_back({in_t'('0),                             out_t'('0)});
    vq.push_back({in_t'('0),                             ers(1, 32'd0, 1'b1)});

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k].i);
      #1 chk($sformatf("vec%0d", k), vq[k].o);
    end

    // Reset during ISSUE of an m1 write aborts it.
    @(negedge clk);
    drive(p1(1'b1, 32'd7, 32'hCAFEF00D));
    #1 chk("abort_gnt", eg(1));
    @(negedge clk);
    drive('0);
    #1 chk("abort_issue", eiss(1'b1, 32'd7, 32'hCAFEF00D));
    #1 rst_n = 1'b0;
    #1 chk("abort_drop", '0);
    drive(both);
    #1 chk("abort_rst_req", '0);
    @(negedge clk);
    chk("abort_rst_hold", '0);
    rst_n = 1'b1;
    #1 chk("post_rst_gnt", eg(0));
    @(negedge clk);
    #1 chk("post_rst_issue", eiss(1'b0, 32'd1, 32'd0));
    @(negedge clk);
    #1 chk("post_rst_resp", ers(0, 32'd1, 1'b0));
    @(negedge clk);
    #1 chk("post_rst_rearb", eg(1));

    n_checks++;
    if (mem[7] !== 32'd7) begin
      n_errs++;
      $display("FAIL abort_mem7: got %h expected %h", mem[7], 32'd7);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
